// File: rtl/fft_vis_pkg.sv
// Shared types and constants for the FFT visualizer back end.
package fft_vis_pkg;

    localparam int unsigned NBINS_DEF = 16;
    localparam int unsigned LVL_W     = 5;
    localparam int unsigned LVL_MAX   = 16;
    localparam int unsigned MAG_W     = 17;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    typedef logic [LVL_W-1:0] level_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        PUBLISH
    } state_t;

endpackage

// File: rtl/fft_mag_approx.sv
// Combinational alpha-max/beta-min magnitude (max + min/2) and log2 bar level of one bin.
module fft_mag_approx
    import fft_vis_pkg::*;
(
    input  cplx_t            bin,
    output logic [MAG_W-1:0] mag_c,
    output level_t           level_c
);

    logic [MAG_W-1:0] abs_re;
    logic [MAG_W-1:0] abs_im;
    logic [MAG_W-1:0] mx;
    logic [MAG_W-1:0] mn;
    level_t           lvl_raw;

    // 17-bit abs so that -32768 maps to 32768
    always_comb begin
        abs_re = bin.re[15] ? (~{bin.re[15], bin.re} + MAG_W'(1)) : {1'b0, bin.re};
        abs_im = bin.im[15] ? (~{bin.im[15], bin.im} + MAG_W'(1)) : {1'b0, bin.im};
        mx     = (abs_re > abs_im) ? abs_re : abs_im;
        mn     = (abs_re > abs_im) ? abs_im : abs_re;
        mag_c  = mx + (mn >> 1);
    end

    // Level is the index of the highest set bit plus one, clamped to LVL_MAX
    always_comb begin
        lvl_raw = '0;
        for (int i = 0; i < int'(MAG_W); i++) begin
            if (mag_c[i]) begin
                lvl_raw = LVL_W'(i + 1);
            end
        end
        level_c = (lvl_raw > level_t'(LVL_MAX)) ? level_t'(LVL_MAX) : lvl_raw;
    end

endmodule

// File: rtl/spectrum_bar_stage.sv
// Captures one FFT frame, converts bins to bar levels one per cycle with peak-hold/decay,
// then publishes the complete set of bars in a single cycle.
module spectrum_bar_stage
    import fft_vis_pkg::*;
#(
    parameter int unsigned NBINS        = NBINS_DEF,
    parameter int unsigned DECAY_FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   f_valid,
    input  logic [NBINS*32-1:0]    f_bins,
    output logic [NBINS*LVL_W-1:0] bars,
    output logic                   bars_valid,
    output logic                   busy,
    output logic [7:0]             drop_cnt
);

    localparam int unsigned IDX_W  = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam int unsigned FCNT_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam int unsigned BAR_W  = NBINS * LVL_W;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [7:0]        drop_q, drop_d;
    logic [BAR_W-1:0]  bars_q, bars_d;
    logic              bars_valid_q, bars_valid_d;
    logic              busy_q, busy_d;
    cplx_t             cap_q  [NBINS];
    cplx_t             cap_d  [NBINS];
    level_t            held_q [NBINS];
    level_t            held_d [NBINS];
    level_t            work_q [NBINS];
    level_t            work_d [NBINS];

    logic [MAG_W-1:0]  mag_c;
    level_t            level_c;
    level_t            lvl_c;
    level_t            held_cur_c;
    level_t            decayed_c;
    level_t            new_held_c;
    logic              tick_c;

    fft_mag_approx u_mag (
        .bin     (cap_q[idx_q]),
        .mag_c   (mag_c),
        .level_c (level_c)
    );

    // Peak-hold with decay on the frame where the frame counter wraps
    always_comb begin
        tick_c     = (fcnt_q == FCNT_W'(DECAY_FRAMES - 1));
        lvl_c      = (mag_c == '0) ? '0 : level_c;
        held_cur_c = held_q[idx_q];
        decayed_c  = (tick_c && (held_cur_c != '0)) ? (held_cur_c - level_t'(1)) : held_cur_c;
        new_held_c = (lvl_c > decayed_c) ? lvl_c : decayed_c;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fcnt_d       = fcnt_q;
        drop_d       = drop_q;
        bars_d       = bars_q;
        bars_valid_d = 1'b0;
        cap_d        = cap_q;
        held_d       = held_q;
        work_d       = work_q;

        unique case (state_q)
            IDLE: begin
                if (f_valid) begin
                    for (int i = 0; i < int'(NBINS); i++) begin
                        cap_d[i] = cplx_t'(f_bins[32*i +: 32]);
                    end
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                held_d[idx_q] = new_held_c;
                work_d[idx_q] = new_held_c;
                if (idx_q == IDX_W'(NBINS - 1)) begin
                    state_d = PUBLISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            PUBLISH: begin
                for (int i = 0; i < int'(NBINS); i++) begin
                    bars_d[LVL_W*i +: LVL_W] = work_q[i];
                end
                bars_valid_d = 1'b1;
                fcnt_d       = tick_c ? '0 : (fcnt_q + FCNT_W'(1));
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Frames arriving outside IDLE are lost; count them, saturating
        if (f_valid && (state_q != IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            fcnt_q       <= '0;
            drop_q       <= '0;
            bars_q       <= '0;
            bars_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < int'(NBINS); i++) begin
                cap_q[i]  <= '0;
                held_q[i] <= '0;
                work_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fcnt_q       <= fcnt_d;
            drop_q       <= drop_d;
            bars_q       <= bars_d;
            bars_valid_q <= bars_valid_d;
            busy_q       <= busy_d;
            cap_q        <= cap_d;
            held_q       <= held_d;
            work_q       <= work_d;
        end
    end

    assign bars       = bars_q;
    assign bars_valid = bars_valid_q;
    assign busy       = busy_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_spectrum_bar_stage.sv
// Randomized bench for spectrum_bar_stage against a frame-level peak-hold model.
module tb_spectrum_bar_stage;

    localparam int NB    = 16;
    localparam int DF    = 2;
    localparam int LW    = 5;
    localparam int BW    = NB * LW;
    localparam int LAT   = NB + 1;

    typedef int arr_t [NB];

    logic              clk;
    logic              rst_n;
    logic              f_valid;
    logic [NB*32-1:0]  f_bins;
    logic [BW-1:0]     bars;
    logic              bars_valid;
    logic              busy;
    logic [7:0]        drop_cnt;

    int   n_checks;
    int   n_errors;
    arr_t held_m;
    arr_t pub_m;
    arr_t next_m;
    int   fcnt_m;
    int   drop_m;

    spectrum_bar_stage #(
        .NBINS        (NB),
        .DECAY_FRAMES (DF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_valid    (f_valid),
        .f_bins     (f_bins),
        .bars       (bars),
        .bars_valid (bars_valid),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Level of one {re,im} bin straight from the arithmetic definition
    function automatic int lvl_of(input logic [31:0] w);
        int re, im, a, b, m, l;
        re = int'($signed(w[31:16]));
        im = int'($signed(w[15:0]));
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        m  = ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
        l  = 0;
        while ((1 << l) <= m) l++;
        return (l > 16) ? 16 : l;
    endfunction

    function automatic logic [BW-1:0] pack(input arr_t a);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) v[LW*i +: LW] = LW'(a[i]);
        return v;
    endfunction

    function automatic logic [31:0] rand_bin();
        logic [15:0] re, im;
        re = 16'($urandom);
        im = 16'($urandom);
        re = 16'($signed(re) >>> $urandom_range(0, 15));
        im = 16'($signed(im) >>> $urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) re = 16'h8000;
        if ($urandom_range(0, 15) == 0) im = 16'h0000;
        return {re, im};
    endfunction

    function automatic logic [NB*32-1:0] rand_frame();
        logic [NB*32-1:0] f;
        for (int i = 0; i < NB; i++) f[32*i +: 32] = rand_bin();
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            held_m[i] = 0;
            pub_m[i]  = 0;
            next_m[i] = 0;
        end
        fcnt_m = 0;
        drop_m = 0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        f_valid = 1'b0;
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // Offer a frame in IDLE and update the model as the frame will be processed
    task automatic send_frame(input logic [NB*32-1:0] fb);
        bit tick;
        int lv, d;
        f_valid = 1'b1;
        f_bins  = fb;
        step();
        f_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("valid_pulse_end", bars_valid, 0);
        tick = (fcnt_m == DF - 1);
        for (int i = 0; i < NB; i++) begin
            lv = lvl_of(fb[32*i +: 32]);
            d  = held_m[i];
            if (tick && d > 0) d--;
            held_m[i] = (lv > d) ? lv : d;
            next_m[i] = held_m[i];
        end
        fcnt_m = (fcnt_m + 1) % DF;
    endtask

    // mode: 0 quiet, 1 pulses at cycles 5 and 17, 2 random pulses, 3 pulse every busy cycle
    task automatic wait_publish(input int mode);
        int lat;
        lat = 0;
        while (1) begin
            f_valid = 1'b0;
            if (lat < LAT) begin
                case (mode)
                    1:       f_valid = ((lat + 1) == 5) || ((lat + 1) == 17);
                    2:       f_valid = 1'($urandom_range(0, 1));
                    3:       f_valid = 1'b1;
                    default: f_valid = 1'b0;
                endcase
                if (f_valid && drop_m < 255) drop_m++;
            end
            f_bins = rand_frame();
            step();
            f_valid = 1'b0;
            lat++;
            if (bars_valid) break;
            check("bars_hold", bars, pack(pub_m));
            check("busy_mid", busy, 1);
            if (lat >= 3 * LAT) begin
                check("publish_timeout", 0, 1);
                return;
            end
        end
        check("latency", lat, LAT);
        check("bars_pub", bars, pack(next_m));
        check("busy_pub", busy, 0);
        check("drop_cnt", drop_cnt, drop_m);
        pub_m = next_m;
    endtask

    initial begin
        logic [NB*32-1:0] fb;
        int               exp_seq [4];
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        f_valid  = 1'b0;
        f_bins   = '0;
        model_reset();
        repeat (3) step();
        check("rst_bars", bars, 0);
        check("rst_valid", bars_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        step();

        // single strong bin
        fb = '0;
        fb[31:0] = {16'd3000, 16'hF060};
        send_frame(fb);
        wait_publish(0);
        check("t1_bar0", bars[LW-1:0], 13);

        // extreme and smallest nonzero bins
        fb = '0;
        fb[32*5 +: 32] = {16'h8000, 16'h8000};
        fb[32*6 +: 32] = {16'h0001, 16'h0000};
        fb[32*7 +: 32] = {16'h0000, 16'hFFFF};
        send_frame(fb);
        wait_publish(0);
        check("t2_bar5", bars[LW*5 +: LW], 16);
        check("t2_bar6", bars[LW*6 +: LW], 1);
        check("t2_bar7", bars[LW*7 +: LW], 1);

        // decay every second frame, then a stronger peak overrides
        do_reset();
        exp_seq[0] = 13; exp_seq[1] = 12; exp_seq[2] = 12; exp_seq[3] = 11;
        for (int f = 0; f < 4; f++) begin
            fb = '0;
            if (f == 0) fb[31:0] = {16'd3000, 16'hF060};
            send_frame(fb);
            wait_publish(0);
            check("t3_decay", bars[LW-1:0], exp_seq[f]);
        end
        fb = '0;
        fb[31:0] = {16'd20000, 16'd0};
        send_frame(fb);
        wait_publish(0);
        check("t3_jump", bars[LW-1:0], 15);

        // drops at cycles 5 and 17, acceptance at cycle 18
        send_frame(rand_frame());
        wait_publish(1);
        check("t4_drop2", drop_cnt, 2);
        send_frame(rand_frame());
        wait_publish(0);

        // reset in the middle of CALC
        send_frame(rand_frame());
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        check("t5_bars", bars, 0);
        check("t5_busy", busy, 0);
        check("t5_valid", bars_valid, 0);
        check("t5_drop", drop_cnt, 0);
        model_reset();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check("t5_quiet", {bars_valid, busy, bars}, 0);
        end
        send_frame(rand_frame());
        wait_publish(0);

        // saturation sweep: every busy cycle carries a dropped pulse
        for (int f = 0; f < 18; f++) begin
            send_frame(rand_frame());
            wait_publish(3);
        end
        check("t6_sat", drop_cnt, 255);

        // random traffic
        for (int f = 0; f < 8; f++) begin
            send_frame(rand_frame());
            wait_publish(2);
        end
        step();
        check("end_valid", bars_valid, 0);
        check("end_bars", bars, pack(pub_m));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
